// File: rtl/fp_accum_engine_pkg.sv
// Shared definitions for the Black-Scholes datapath: engine state encoding,
// FP32 constants and a classification helper.
package bs_defs;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_REDUCE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

   function automatic logic fp_is_inf_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF);
   endfunction

endpackage

// File: rtl/fp_accum_engine_add.sv
// Pipelined FP32 adder of latency ADD_LAT; behavioural stand-in for the vendor
// core with round-to-nearest-even, Inf/NaN and subnormal handling.
module fp_add_pipe #(
   parameter int ADD_LAT = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);

   function automatic logic [31:0] fp_add32(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] big;
      logic [31:0] sml;
      logic [27:0] xb;
      logic [27:0] xs;
      logic [27:0] mask;
      logic [27:0] acc;
      logic [8:0]  d;
      logic [24:0] rnd;
      logic [23:0] mant;
      logic [7:0]  eb_f;
      logic [7:0]  es_f;
      logic        sticky;
      logic        up;
      int          e;
      if ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) return 32'h7FC0_0000;
      if ((y[30:23] == 8'hFF) && (y[22:0] != 23'd0)) return 32'h7FC0_0000;
      if ((x[30:23] == 8'hFF) && (y[30:23] == 8'hFF) && (x[31] != y[31])) return 32'h7FC0_0000;
      big = (x[30:0] >= y[30:0]) ? x : y;
      sml = (x[30:0] >= y[30:0]) ? y : x;
      if (big[30:23] == 8'hFF) return big;
      eb_f = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
      es_f = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
      xb   = {1'b0, (big[30:23] != 8'd0), big[22:0], 3'b000};
      xs   = {1'b0, (sml[30:23] != 8'd0), sml[22:0], 3'b000};
      d    = {1'b0, eb_f} - {1'b0, es_f};
      // guard/round bits plus a sticky LSB keep RNE exact for add and subtract
      if (d > 9'd27) begin
         sticky = (xs != 28'd0);
         xs     = 28'd0;
      end else begin
         mask   = (28'd1 << d) - 28'd1;
         sticky = ((xs & mask) != 28'd0);
         xs     = xs >> d;
      end
      xs[0] = xs[0] | sticky;
      acc   = (x[31] != y[31]) ? (xb - xs) : (xb + xs);
      if (acc == 28'd0) return {x[31] & y[31], 31'd0};
      e = int'(eb_f);
      if (acc[27]) begin
         acc = {1'b0, acc[27:2], acc[1] | acc[0]};
         e   = e + 1;
      end else begin
         for (int i = 0; i < 26; i++) begin
            if (!acc[26] && (e > 1)) begin
               acc = acc << 1;
               e   = e - 1;
            end
         end
      end
      up  = acc[2] & (acc[1] | acc[0] | acc[3]);
      rnd = {1'b0, acc[26:3]} + {24'd0, up};
      if (rnd[24]) begin
         mant = rnd[24:1];
         e    = e + 1;
      end else begin
         mant = rnd[23:0];
      end
      if (e >= 255) return {big[31], 8'hFF, 23'd0};
      return {big[31], (mant[23] ? e[7:0] : 8'd0), mant[22:0]};
   endfunction

   logic [31:0] stage_r [ADD_LAT];

   // sum is formed on entry and then delayed so the total latency is ADD_LAT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ADD_LAT; i++) stage_r[i] <= 32'd0;
      end else begin
         stage_r[0] <= fp_add32(a, b);
         for (int i = 1; i < ADD_LAT; i++) stage_r[i] <= stage_r[i-1];
      end
   end

   assign sum = stage_r[ADD_LAT-1];

endmodule

// File: rtl/fp_accum_engine.sv
// Streaming FP32 series accumulator: one partial sum per adder pipeline slot,
// then a fixed-order reduction of the partial sums into a single result.
module fp_accum_engine
   import bs_defs::*;
#(
   parameter int ADD_LAT = 7,
   parameter int MAX_N   = 1024,
   parameter int CNT_W   = $clog2(MAX_N + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] n_terms,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic [31:0]      result,
   output logic [2:0]       status
);

   localparam int PH_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
   localparam int WC_W = $clog2(ADD_LAT + 1);
   localparam int IDX1 = (ADD_LAT > 1) ? 1 : 0;
   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(ADD_LAT - 1);
   localparam logic [WC_W-1:0]  WC_FULL = WC_W'(ADD_LAT);
   localparam logic [CNT_W-1:0] N_MAX   = CNT_W'(MAX_N);

   state_t           state_r, state_s;
   logic [PH_W-1:0]  ph_r, drain_r, red_k_r, red_nx_s;
   logic [WC_W-1:0]  warm_r, red_cnt_r;
   logic [CNT_W-1:0] acc_cnt_r, n_r, acc_nx_s, n_nx_s, n_clamp_s;
   logic [31:0]      psum_r [ADD_LAT];
   logic [31:0]      add_a_s, add_b_s, add_out_s, pv0_s, pv1_s, result_r;
   logic             accept_s, start_ok_s, start_ign_s, last_drain_s, red_hit_s, red_last_s;
   logic             done_r, busy_r, in_ready_r, inf_r, ign_r;

   fp_add_pipe #(.ADD_LAT(ADD_LAT)) u_add (
      .clk   (clk),
      .reset (reset),
      .a     (add_a_s),
      .b     (add_b_s),
      .sum   (add_out_s)
   );

   assign accept_s     = (state_r == ST_LOAD) && in_valid && in_ready_r;
   assign start_ok_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
   assign start_ign_s  = start && ((state_r == ST_LOAD) || (state_r == ST_DRAIN) || (state_r == ST_REDUCE));
   assign n_clamp_s    = (n_terms > N_MAX) ? N_MAX : n_terms;
   assign last_drain_s = (state_r == ST_DRAIN) && (drain_r == PH_LAST);
   assign red_hit_s    = (state_r == ST_REDUCE) && (red_cnt_r == WC_FULL);
   assign red_last_s   = red_hit_s && (red_k_r == PH_LAST);
   assign red_nx_s     = red_k_r + PH_W'(1);
   // the lane being captured in the last drain cycle is forwarded straight from the adder
   assign pv0_s        = (ph_r == PH_W'(0)) ? add_out_s : psum_r[0];
   assign pv1_s        = (ph_r == PH_W'(IDX1)) ? add_out_s : psum_r[IDX1];
   assign acc_nx_s     = start_ok_s ? '0 : (acc_cnt_r + CNT_W'(accept_s));
   assign n_nx_s       = start_ok_s ? n_clamp_s : n_r;

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= state_s;
   end

   // next state and adder operand selection
   always_comb begin
      state_s = state_r;
      add_a_s = FP_ZERO;
      add_b_s = FP_ZERO;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start_ok_s) state_s = (n_clamp_s == '0) ? ST_DONE : ST_LOAD;
            else            state_s = ST_IDLE;
         end
         ST_LOAD: begin
            add_a_s = accept_s ? in_data : FP_ZERO;
            add_b_s = (warm_r == WC_FULL) ? add_out_s : FP_ZERO;
            if ((acc_cnt_r == n_r) && (warm_r == WC_FULL)) state_s = ST_DRAIN;
            else                                           state_s = ST_LOAD;
         end
         ST_DRAIN: begin
            if (last_drain_s) begin
               if (ADD_LAT == 1) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_REDUCE;
                  add_a_s = pv0_s;
                  add_b_s = pv1_s;
               end
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_REDUCE: begin
            if (red_last_s) begin
               state_s = ST_DONE;
            end else if (red_hit_s) begin
               add_a_s = add_out_s;
               add_b_s = psum_r[red_nx_s];
            end else begin
               state_s = ST_REDUCE;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // counters, partial sums and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ph_r       <= '0;
         drain_r    <= '0;
         red_k_r    <= '0;
         warm_r     <= '0;
         red_cnt_r  <= '0;
         acc_cnt_r  <= '0;
         n_r        <= '0;
         for (int i = 0; i < ADD_LAT; i++) psum_r[i] <= 32'd0;
         result_r   <= 32'd0;
         done_r     <= 1'b0;
         busy_r     <= 1'b0;
         in_ready_r <= 1'b0;
         inf_r      <= 1'b0;
         ign_r      <= 1'b0;
      end else begin
         done_r     <= 1'b0;
         acc_cnt_r  <= acc_nx_s;
         n_r        <= n_nx_s;
         in_ready_r <= (state_s == ST_LOAD) && (acc_nx_s < n_nx_s);
         busy_r     <= (state_s == ST_LOAD) || (state_s == ST_DRAIN) || (state_s == ST_REDUCE);
         if (start_ok_s)       ign_r <= 1'b0;
         else if (start_ign_s) ign_r <= 1'b1;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start_ok_s) begin
                  warm_r  <= '0;
                  ph_r    <= '0;
                  drain_r <= '0;
                  if (n_clamp_s == '0) begin
                     result_r <= FP_ZERO;
                     inf_r    <= 1'b0;
                     done_r   <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               ph_r <= (ph_r == PH_LAST) ? '0 : (ph_r + PH_W'(1));
               if (warm_r != WC_FULL) warm_r <= warm_r + WC_W'(1);
            end
            ST_DRAIN: begin
               psum_r[ph_r] <= add_out_s;
               ph_r         <= (ph_r == PH_LAST) ? '0 : (ph_r + PH_W'(1));
               drain_r      <= drain_r + PH_W'(1);
               if (last_drain_s) begin
                  red_k_r   <= PH_W'(IDX1);
                  red_cnt_r <= WC_W'(1);
                  if (ADD_LAT == 1) begin
                     result_r <= pv0_s;
                     inf_r    <= fp_is_inf_nan(pv0_s);
                     done_r   <= 1'b1;
                  end
               end
            end
            ST_REDUCE: begin
               if (red_last_s) begin
                  result_r <= add_out_s;
                  inf_r    <= fp_is_inf_nan(add_out_s);
                  done_r   <= 1'b1;
               end else if (red_hit_s) begin
                  red_k_r   <= red_nx_s;
                  red_cnt_r <= WC_W'(1);
               end else begin
                  red_cnt_r <= red_cnt_r + WC_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready = in_ready_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign result   = result_r;
   assign status   = {ign_r, inf_r, busy_r};

endmodule

// File: tb/tb_fp_accum_engine.sv
// Directed self-checking bench for fp_accum_engine with ADD_LAT = 7.
module tb_fp_accum_engine;

   localparam int L     = 7;
   localparam int MAX_N = 1024;
   localparam int CNT_W = 11;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [CNT_W-1:0] n_terms;
   logic             in_valid;
   logic [31:0]      in_data;
   logic             in_ready;
   logic             busy;
   logic             done;
   logic [31:0]      result;
   logic [2:0]       status;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic [31:0] terms [$];

   fp_accum_engine #(.ADD_LAT(L), .MAX_N(MAX_N), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .n_terms  (n_terms),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .status   (status)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic int exp_done(input int s_c, input int a_c);
      int e;
      e = (a_c + 1 > s_c + 1 + L) ? a_c + 1 : s_c + 1 + L;
      return e + L + (L - 1) * L + 1;
   endfunction

   task automatic run_engine(input int n, input bit toggle, output int s_c, output int a_c,
                             output int d_c, output logic rdy_after, output logic saw_rdy,
                             output logic [2:0] st_first, output bit to);
      int acc = 0;
      bit vph = 1'b0;
      bit got = 1'b0;
      to = 1'b0; a_c = -1000; d_c = -1; rdy_after = 1'bx; saw_rdy = 1'b0; st_first = 3'bxxx;
      start = 1'b1; n_terms = n[CNT_W-1:0]; in_valid = 1'b0; s_c = cyc;
      step();
      start = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
         if (cyc == s_c + 1) st_first = status;
         if (done) begin
            got = 1'b1;
            d_c = cyc;
         end else begin
            if (cyc == a_c + 1) rdy_after = in_ready;
            if (in_ready) saw_rdy = 1'b1;
            in_valid = toggle ? vph : 1'b1;
            vph      = ~vph;
            in_data  = (acc < terms.size()) ? terms[acc] : 32'hDEAD_BEEF;
            if (in_valid && in_ready) begin
               acc++;
               a_c = cyc;
            end
            step();
         end
      end
      in_valid = 1'b0;
      to = !got;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", result); end
      checks++; if (status !== 3'b000) begin failures++; $display("FAIL reset_status got=%b exp=000", status); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_sum28();
      int s_c, a_c, d_c; logic ra, sr; logic [2:0] sf; bit to;
      terms.delete();
      for (int i = 0; i < 28; i++) terms.push_back(32'h3F80_0000);
      run_engine(28, 1'b0, s_c, a_c, d_c, ra, sr, sf, to);
      checks++; if (to) begin failures++; $display("FAIL sum28_timeout got=no_done exp=done"); end
      checks++; if (result !== 32'h41E0_0000) begin failures++; $display("FAIL sum28_result got=%h exp=41e00000", result); end
      checks++; if (d_c !== exp_done(s_c, a_c)) begin failures++; $display("FAIL sum28_latency got=%0d exp=%0d", d_c - s_c, exp_done(s_c, a_c) - s_c); end
      checks++; if (sf !== 3'b001) begin failures++; $display("FAIL sum28_busy_status got=%b exp=001", sf); end
      checks++; if (status !== 3'b000) begin failures++; $display("FAIL sum28_done_status got=%b exp=000", status); end
      step();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL sum28_done_pulse got=%b exp=0", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sum28_busy_after got=%b exp=0", busy); end
   endtask

   task automatic test_zero();
      int s_c, a_c, d_c; logic ra, sr; logic [2:0] sf; bit to;
      terms.delete();
      run_engine(0, 1'b0, s_c, a_c, d_c, ra, sr, sf, to);
      checks++; if (d_c !== s_c + 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", d_c - s_c); end
      checks++; if (result !== 32'h0) begin failures++; $display("FAIL zero_result got=%h exp=00000000", result); end
      checks++; if (sr !== 1'b0) begin failures++; $display("FAIL zero_in_ready got=%b exp=0", sr); end
   endtask

   task automatic test_three();
      int s_c, a_c, d_c; logic ra, sr; logic [2:0] sf; bit to;
      terms = '{32'h3F80_0000, 32'h4000_0000, 32'h4080_0000};
      run_engine(3, 1'b0, s_c, a_c, d_c, ra, sr, sf, to);
      checks++; if (result !== 32'h40E0_0000) begin failures++; $display("FAIL three_result got=%h exp=40e00000", result); end
      checks++; if (d_c !== s_c + 1 + L + 50) begin failures++; $display("FAIL three_latency got=%0d exp=%0d", d_c - s_c, 1 + L + 50); end
      checks++; if (ra !== 1'b0) begin failures++; $display("FAIL three_ready_drop got=%b exp=0", ra); end
   endtask

   task automatic test_toggle();
      int s_c, a_c, d_c; logic ra, sr; logic [2:0] sf; bit to;
      terms.delete();
      for (int i = 0; i < 10; i++) terms.push_back(32'h3F80_0000);
      run_engine(10, 1'b1, s_c, a_c, d_c, ra, sr, sf, to);
      checks++; if (result !== 32'h4120_0000) begin failures++; $display("FAIL toggle_result got=%h exp=41200000", result); end
      checks++; if (a_c !== s_c + 20) begin failures++; $display("FAIL toggle_last_accept got=%0d exp=20", a_c - s_c); end
      checks++; if (ra !== 1'b0) begin failures++; $display("FAIL toggle_ready_drop got=%b exp=0", ra); end
      checks++; if (d_c !== s_c + 71) begin failures++; $display("FAIL toggle_latency got=%0d exp=71", d_c - s_c); end
   endtask

   task automatic test_ignore_start();
      int s_c, a_c, d_c; logic ra, sr; logic [2:0] sf; bit to; bit got;
      start = 1'b1; n_terms = 11'd5; s_c = cyc;
      step();
      start = 1'b0; in_valid = 1'b1; in_data = 32'h3F80_0000;
      repeat (24) step();
      in_valid = 1'b0; start = 1'b1; n_terms = 11'd2;
      step();
      start = 1'b0;
      checks++; if (status !== 3'b101) begin failures++; $display("FAIL ignore_sticky got=%b exp=101", status); end
      got = 1'b0; d_c = -1;
      for (int k = 0; k < 100 && !got; k++) begin
         if (done) begin got = 1'b1; d_c = cyc; end
         else step();
      end
      checks++; if (d_c !== s_c + 58) begin failures++; $display("FAIL ignore_latency got=%0d exp=58", d_c - s_c); end
      checks++; if (result !== 32'h40A0_0000) begin failures++; $display("FAIL ignore_result got=%h exp=40a00000", result); end
      checks++; if (status[2] !== 1'b1) begin failures++; $display("FAIL ignore_sticky_held got=%b exp=1", status[2]); end
      // next run launched in the done cycle; its start clears the sticky flag
      terms = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
      run_engine(4, 1'b0, s_c, a_c, d_c, ra, sr, sf, to);
      checks++; if (sf !== 3'b001) begin failures++; $display("FAIL ignore_sticky_clear got=%b exp=001", sf); end
      checks++; if (result !== 32'h4100_0000) begin failures++; $display("FAIL after_ignore_result got=%h exp=41000000", result); end
   endtask

   task automatic test_reset_mid();
      int s_c, a_c, d_c; logic ra, sr; logic [2:0] sf; bit to;
      start = 1'b1; n_terms = 11'd28;
      step();
      start = 1'b0; in_valid = 1'b1; in_data = 32'h4040_0000;
      repeat (5) step();
      reset = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      checks++; if (result !== 32'h0) begin failures++; $display("FAIL midrst_result got=%h exp=00000000", result); end
      checks++; if (status !== 3'b000) begin failures++; $display("FAIL midrst_status got=%b exp=000", status); end
      in_valid = 1'b0;
      step();
      reset = 1'b0;
      step();
      terms = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
      run_engine(4, 1'b0, s_c, a_c, d_c, ra, sr, sf, to);
      checks++; if (result !== 32'h4100_0000) begin failures++; $display("FAIL midrst_rerun_result got=%h exp=41000000", result); end
      checks++; if (d_c !== s_c + 58) begin failures++; $display("FAIL midrst_rerun_latency got=%0d exp=58", d_c - s_c); end
   endtask

   task automatic test_overflow();
      int s_c, a_c, d_c; logic ra, sr; logic [2:0] sf; bit to;
      terms = '{32'h7F7F_FFFF, 32'h7F7F_FFFF};
      run_engine(2, 1'b0, s_c, a_c, d_c, ra, sr, sf, to);
      checks++; if (result !== 32'h7F80_0000) begin failures++; $display("FAIL ovf_result got=%h exp=7f800000", result); end
      checks++; if (status !== 3'b010) begin failures++; $display("FAIL ovf_status got=%b exp=010", status); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; n_terms = '0; in_valid = 1'b0; in_data = 32'h0;
      test_reset();
      test_sum28();
      test_zero();
      test_three();
      test_toggle();
      test_ignore_start();
      test_reset_mid();
      test_overflow();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp_accum_engine.md
# fp_accum_engine

Parametrised floating-point accumulation engine for the Black-Scholes processor. Sums a stream of `n_terms` IEEE-754 single-precision values through one pipelined FP adder of latency `ADD_LAT`, then returns one result with a done pulse. Each adder pipeline slot carries its own partial sum, so a term is accepted every cycle despite the adder latency; a final reduction merges the partial sums. Feeds the pricing datapath wherever a series sum is needed.

## Interface
- `ADD_LAT`, 7: FP adder pipeline latency in cycles; must be ≥1.
- `MAX_N`, 1024: maximum terms per run.
- `CNT_W`, $clog2(MAX_N+1): width of the term counter.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: run request pulse; sampled in IDLE and DONE only.
- `n_terms` in CNT_W: terms in this run; values above MAX_N clamp to MAX_N.
- `in_valid` in 1: `in_data` valid.
- `in_data` in 32: FP32 term.
- `in_ready` out 1: term accepted when `in_valid && in_ready`.
- `busy` out 1: high outside IDLE and DONE.
- `done` out 1: one-cycle pulse when `result` updates.
- `result` out 32: final sum; held until the next run completes.
- `status` out 3:
  - [0] = busy.
  - [1] = result is Inf/NaN (exponent all ones).
  - [2] = sticky start-ignored; cleared on the next accepted start.

## Operation
- Reset values: state IDLE; `in_ready`, `busy`, `done` = 0; `result` = 32'h0; `status` = 0.
- Phase counter `ph` (mod ADD_LAT) increments every cycle in LOAD and DRAIN. The adder output at cycle c belongs to lane `ph(c)`.
- IDLE/DONE, on `start`:
  - n = 0: go to DONE; `result` = +0.0; `done` pulses.
  - otherwise: latch n, clear the accept counter and warm counter, go to LOAD.
- LOAD:
  - `in_ready` = (accepted < n).
  - Adder operand a = `in_data` on acceptance, else +0.0.
  - Adder operand b = adder output, masked to +0.0 for the first ADD_LAT LOAD cycles (warm-up).
  - Exit to DRAIN when accepted == n and warm count ≥ ADD_LAT. LOAD therefore lasts at least ADD_LAT cycles.
- DRAIN, ADD_LAT cycles: capture the adder output into `psum[ph]`; adder inputs don't-care.
- REDUCE:
  - acc = `psum[0]`.
  - For k = 1..ADD_LAT−1: issue acc + `psum[k]`, wait ADD_LAT cycles, and take the result as the new acc.
  - Then go to DONE with `result` ← acc and `done` = 1 for that cycle.
- Summation order is fixed, so results are bit-exact against a model:
  - Lane j = sequential sum of terms i ≡ j mod ADD_LAT, starting from +0.0.
  - Final = ((lane0 + lane1) + lane2)…
- `start` in LOAD, DRAIN or REDUCE is ignored and sets `status[2]`.
- `in_valid` outside LOAD is ignored.
- Reset mid-run: immediate return to reset values; partial sums discarded; the warm-up masking covers stale adder contents on the next run.

## Timing
- Throughput: 1 term/cycle in LOAD; bubbles on `in_valid` are allowed.
- E = last LOAD cycle. `done` is high in cycle E + ADD_LAT + (ADD_LAT−1)·ADD_LAT + 1.
  - ADD_LAT = 7: E + 50.
  - ADD_LAT = 1: E + 2.
- n = 0: `done` is high the cycle after `start`.
- `in_ready` drops in the cycle after the n-th acceptance.
- `start` may be asserted in the same cycle as `done`; it is accepted.

## Structure
- Shared package `bs_defs`:
  - state encoding IDLE/LOAD/DRAIN/REDUCE/DONE;
  - FP_ZERO = 32'h00000000, FP_ONE = 32'h3F800000;
  - function `fp_is_inf_nan`.
- Sub-module `fp_add_pipe`: ADD_LAT-parametrised wrapper around the vendor `altfp_add`. The bench uses a behavioural model with identical latency.
- Partial-sum storage: ADD_LAT×32 register array.

## Test plan
- n = 28, all 1.0 (0x3F800000), `in_valid` constant → `result` 0x41E00000 (28.0); `done` at E+50; `busy` low after.
- n = 0 → `result` 0x00000000 and `done` the cycle after `start`; no `in_ready`.
- n = 3, terms 1.0, 2.0, 4.0 → LOAD held ADD_LAT cycles; `result` 0x40E00000 (7.0).
- n = 10 of 1.0, `in_valid` toggling every cycle → `result` 0x41200000; `in_ready` low after the 10th acceptance.
- `start` pulsed in REDUCE → ignored, `status[2]` = 1. `reset` asserted mid-LOAD → all outputs at reset values. The following run with n = 4 of 2.0 → 0x41000000, and `status[2]` clears on its start.
- n = 2, both 0x7F7FFFFF → `result` 0x7F800000, `status[1]` = 1.
